// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: gates the UART receiver, buffers bytes in a show-ahead FIFO, filters BREAKs, reports status
module uart_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BREAK_HOLD  = 1024,
  parameter int IDLE_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          rx_valid,
  input  logic                          rx_break,
  input  logic [7:0]                    rx_data,
  output logic                          rx_en,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          break_det,
  output logic                          overrun,
  output logic [7:0]                    overrun_cnt,
  output logic                          idle,
  input  logic                          clr_status
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  typedef enum logic [1:0] {OFF, RUN, HOLD, BRK} state_t;
  state_t state, state_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] lvl, lvl_nx;
  logic [15:0] hcnt, icnt;
  logic brk_byte, push, pop, full, wr, drop;
  assign brk_byte    = rx_valid & rx_break;
  assign push        = rx_valid & ~rx_break & (state != OFF);
  assign pop         = out_valid & out_ready;
  assign full        = lvl == FULL;
  assign wr          = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign lvl_nx      = lvl + LW'(wr) - LW'(pop);
  assign out_valid   = lvl != '0;
  assign out_data    = mem[rp];
  assign fifo_level  = lvl;
  assign rx_en       = state == RUN;
  assign idle        = icnt >= 16'(IDLE_CYCLES);
  // next state in priority order: disable, enable, break, fill, drain, break timeout
  always_comb begin
    state_nx = state;
    state_nx = !enable                                       ? OFF  :
               state == OFF                                  ? RUN  :
               (state == RUN || state == HOLD) && brk_byte   ? BRK  :
               state == RUN && lvl_nx == FULL                ? HOLD :
               state == HOLD && lvl_nx < FULL                ? RUN  :
               state == BRK && hcnt == '0                    ? (lvl_nx == FULL ? HOLD : RUN) :
                                                               state;
  end
  // state register and break hold-off counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == BRK && state != BRK) hcnt <= 16'(BREAK_HOLD - 1);
      else if (state == BRK && hcnt != '0) hcnt <= hcnt - 16'd1;
    end
  end
  // byte FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr) begin
        mem[wp] <= rx_data;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      lvl <= lvl_nx;
    end
  end
  // break pulse, overrun status (drop beats clear) and saturating idle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      break_det   <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
      icnt        <= '0;
    end else begin
      break_det   <= brk_byte & (state != OFF);
      overrun     <= drop | (overrun & ~clr_status);
      overrun_cnt <= drop ? (clr_status ? 8'd1 : (overrun_cnt == 8'hff ? 8'hff : overrun_cnt + 8'd1)) :
                     clr_status ? 8'd0 : overrun_cnt;
      icnt        <= (rx_valid || state == OFF) ? 16'd0 : (icnt == 16'hffff ? icnt : icnt + 16'd1);
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: vector table plus scoreboard check of uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, rx_valid = 1'b0, rx_break = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic out_ready = 1'b0, clr_status = 1'b0;
  logic rx_en, out_valid, break_det, overrun, idle;
  logic [7:0] out_data, overrun_cnt;
  logic [2:0] fifo_level;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  typedef struct {
    logic en, v, b;
    logic [7:0] d;
    logic rdy, clr, acc;
    logic e_en, e_ov;
    int e_lvl;
    logic e_or;
    int e_cnt;
    logic e_bd;
  } vec_t;
  vec_t tv[80];
  int nv = 0;
  uart_rx_ctrl #(.FIFO_DEPTH(4), .BREAK_HOLD(8), .IDLE_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_valid(rx_valid), .rx_break(rx_break),
    .rx_data(rx_data), .rx_en(rx_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fifo_level(fifo_level), .break_det(break_det), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .idle(idle), .clr_status(clr_status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic en, v, b, input logic [7:0] d, input logic rdy, clr, acc,
                     input logic e_en, e_ov, input int e_lvl, input logic e_or, input int e_cnt,
                     input logic e_bd);
    tv[nv].en = en; tv[nv].v = v; tv[nv].b = b; tv[nv].d = d;
    tv[nv].rdy = rdy; tv[nv].clr = clr; tv[nv].acc = acc;
    tv[nv].e_en = e_en; tv[nv].e_ov = e_ov; tv[nv].e_lvl = e_lvl;
    tv[nv].e_or = e_or; tv[nv].e_cnt = e_cnt; tv[nv].e_bd = e_bd;
    nv++;
  endtask
  task automatic step(input logic en, v, b, input logic [7:0] d, input logic rdy, clr, acc);
    enable = en; rx_valid = v; rx_break = b; rx_data = d; out_ready = rdy; clr_status = clr;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_data", int'(out_data), int'(q.pop_front()));
    end
    if (acc) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_rx_en"}, int'(rx_en), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_level"}, int'(fifo_level), 0);
    chk({tag, "_break_det"}, int'(break_det), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_overrun_cnt"}, int'(overrun_cnt), 0);
    chk({tag, "_idle"}, int'(idle), 0);
  endtask
  initial begin
    add(1,0,0,8'h00,0,0,0, 1,0,0,0,0,0);
    add(1,1,0,8'h41,1,0,1, 1,1,1,0,0,0);
    add(1,1,0,8'h42,1,0,1, 1,1,1,0,0,0);
    add(1,1,0,8'h43,1,0,1, 1,1,1,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,0,0,0,0,0);
    add(1,1,0,8'h10,0,0,1, 1,1,1,0,0,0);
    add(1,1,0,8'h11,0,0,1, 1,1,2,0,0,0);
    add(1,1,0,8'h12,0,0,1, 1,1,3,0,0,0);
    add(1,1,0,8'h13,0,0,1, 0,1,4,0,0,0);
    add(1,1,0,8'h14,0,0,0, 0,1,4,1,1,0);
    add(1,0,0,8'h00,0,0,0, 0,1,4,1,1,0);
    add(1,1,0,8'h55,1,0,1, 0,1,4,1,1,0);
    add(1,0,0,8'h00,0,1,0, 0,1,4,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,3,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,2,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,1,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,0,0,0,0,0);
    add(1,1,0,8'h20,0,0,1, 1,1,1,0,0,0);
    add(1,1,0,8'h21,0,0,1, 1,1,2,0,0,0);
    add(1,1,0,8'h22,0,0,1, 1,1,3,0,0,0);
    add(1,1,0,8'h23,0,0,1, 0,1,4,0,0,0);
    add(1,1,0,8'h24,0,0,0, 0,1,4,1,1,0);
    add(1,1,0,8'h25,0,0,0, 0,1,4,1,2,0);
    add(1,1,0,8'h26,0,1,0, 0,1,4,1,1,0);
    add(1,0,0,8'h00,0,1,0, 0,1,4,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,3,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,2,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,1,1,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,0,0,0,0,0);
    add(1,1,0,8'h77,0,0,1, 1,1,1,0,0,0);
    add(1,1,1,8'h00,0,0,0, 0,1,1,0,0,1);
    for (int i = 0; i < 7; i++) add(1,0,0,8'h00,0,0,0, 0,1,1,0,0,0);
    add(1,0,0,8'h00,0,0,0, 1,1,1,0,0,0);
    add(1,0,0,8'h00,1,0,0, 1,0,0,0,0,0);
    add(0,0,0,8'h00,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,8'h99,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,8'h00,0,0,0, 0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;
    for (int i = 0; i < nv; i++) begin
      step(tv[i].en, tv[i].v, tv[i].b, tv[i].d, tv[i].rdy, tv[i].clr, tv[i].acc);
      chk($sformatf("v%0d_rx_en", i), int'(rx_en), int'(tv[i].e_en));
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(tv[i].e_ov));
      chk($sformatf("v%0d_level", i), int'(fifo_level), tv[i].e_lvl);
      chk($sformatf("v%0d_overrun", i), int'(overrun), int'(tv[i].e_or));
      chk($sformatf("v%0d_overrun_cnt", i), int'(overrun_cnt), tv[i].e_cnt);
      chk($sformatf("v%0d_break_det", i), int'(break_det), int'(tv[i].e_bd));
    end
    step(1,0,0,8'h00,0,0,0);
    chk("idle_run_rx_en", int'(rx_en), 1);
    for (int j = 1; j <= 100; j++) begin
      step(1,0,0,8'h00,0,0,0);
      if (j == 99) chk("idle_early", int'(idle), 0);
    end
    chk("idle_set", int'(idle), 1);
    step(1,1,0,8'h88,0,0,1);
    chk("idle_cleared", int'(idle), 0);
    step(1,1,0,8'h89,0,0,1);
    step(1,1,0,8'h8a,0,0,1);
    chk("pre_reset_level", int'(fifo_level), 3);
    reset = 1'b1;
    step(1,0,0,8'h00,0,0,0);
    chk_reset("midreset");
    reset = 1'b0;
    q.delete();
    step(1,0,0,8'h00,1,0,0);
    chk("post_reset_rx_en", int'(rx_en), 1);
    chk("post_reset_out_valid", int'(out_valid), 0);
    chk("sb_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller placed between the `uart_rx` receiver and the byte consumer. It gates the receiver's `recv_en` from a software enable and the state of its own buffer. It stores completed bytes in a small show-ahead FIFO with a valid/ready output, and filters BREAK frames into an event pulse. It also reports overrun and line-idle status.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: number of byte entries. Must be a power of two, 2–16.
- `BREAK_HOLD`, 1024: number of cycles `rx_en` stays low after a BREAK. Range 1–65535.
- `IDLE_CYCLES`, 20000: number of cycles without a received byte before `idle` asserts. Range 1–65535.

Ports:
- `clk`  in  1  system clock; all logic rises on the posedge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  software receive enable.
- `rx_valid`  in  1  one-cycle byte-complete pulse from the receiver (`recv_valid`).
- `rx_break`  in  1  BREAK indication from the receiver (`break`).
- `rx_data`  in  8  received byte (`recv_data`).
- `rx_en`  out  1  drives the receiver's `recv_en`.
- `out_valid`  out  1  FIFO not empty.
- `out_data`  out  8  FIFO head entry.
- `out_ready`  in  1  consumer accepts the head entry.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `break_det`  out  1  one-cycle pulse when a BREAK frame completes.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `overrun_cnt`  out  8  saturating count of dropped bytes.
- `idle`  out  1  line has been idle for at least IDLE_CYCLES.
- `clr_status`  in  1  clears `overrun` and `overrun_cnt`.

## Operation
- Event definitions:
  - `brk_byte` = `rx_valid & rx_break`.
  - `push` = `rx_valid & ~rx_break & state!=OFF`.
  - `pop` = `out_valid & out_ready`.
- State machine states: OFF, RUN, HOLD, BRK.
- `rx_en` = (state==RUN).
- Transitions, evaluated in priority order:
  1. `enable`=0 → OFF, from any state.
  2. OFF & `enable` → RUN.
  3. RUN/HOLD & `brk_byte` → BRK. The hold counter loads BREAK_HOLD−1.
  4. RUN & next level==FIFO_DEPTH → HOLD.
  5. HOLD & next level<FIFO_DEPTH → RUN.
  6. BRK: the counter decrements each cycle. At counter==0, go to HOLD if the FIFO is full, otherwise RUN.
- FIFO behaviour:
  - Show-ahead: `out_data` is always the head entry. Its value is don't-care while `out_valid`=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - `push` while full and no `pop`: the byte is dropped, `overrun` is set, and `overrun_cnt` increments, saturating at 255.
  - `push` and `pop` in the same cycle while full: both are accepted, the level is unchanged, and there is no overrun.
  - `push` and `pop` in the same cycle while empty: the push is accepted and the level becomes 1. The pop is ignored because `out_valid`=0.
- A byte completing while in OFF (disabled mid-frame) is discarded silently. It does not count as an overrun.
- A `brk_byte` is never pushed. `break_det` pulses on it in every state except OFF.
- `clr_status` together with an overrun drop in the same cycle: the set wins, so `overrun`=1 and `overrun_cnt`=1.
- Idle counter (16 bits):
  - Clears on `rx_valid` or while in OFF.
  - Otherwise increments, saturating.
  - `idle` = counter ≥ IDLE_CYCLES.

## Timing
- Reset values, applied while `reset`=1 (overrides all other inputs):
  - State = OFF.
  - `rx_en`=0, `out_valid`=0, `out_data`=0, `fifo_level`=0.
  - `break_det`=0, `overrun`=0, `overrun_cnt`=0, `idle`=0.
  - FIFO pointers = 0; all counters = 0.
- Reset asserted mid-frame or with a non-empty FIFO: all FIFO contents are discarded.
- Enable path:
  - `enable` rising at cycle t → `rx_en`=1 at t+1.
  - `enable` falling at t → `rx_en`=0 at t+1.
- Push path: `rx_valid` at t → `out_valid`/`fifo_level` updated at t+1, with `out_data` valid at t+1 when the FIFO was empty.
- Pop path: `pop` at t → the next entry appears, or `out_valid` drops, at t+1.
- Status latency:
  - `break_det` is registered: `brk_byte` at t → pulse at t+1, lasting exactly one cycle.
  - `overrun` is set at t+1 after the dropping `rx_valid`.
- `rx_en` deassertion only blocks new start bits. A frame already in progress completes and may overrun.
- BREAK hold-off: `brk_byte` at t → `rx_en`=0 from t+1 through t+BREAK_HOLD, then returns to 1 at t+BREAK_HOLD+1 if there is room.
- Idle flag: `idle` asserts exactly IDLE_CYCLES cycles after the last `rx_valid` (or after entering RUN), provided no further `rx_valid` arrives.

## Test plan
- **Basic receive.** Reset, `enable`=1, push 0x41, 0x42, 0x43 with `out_ready`=1 → `out_data` shows 0x41, 0x42, 0x43 in order; `fifo_level` never exceeds 1; `overrun`=0.
- **Fill and overrun.** `out_ready`=0, DEPTH=4, push 0x10..0x14.
  - After the 4th byte: `rx_en`=0.
  - The 5th byte is dropped: `overrun`=1, `overrun_cnt`=1.
  - Draining yields 0x10..0x13 only.
  - `clr_status` → `overrun`=0, `overrun_cnt`=0.
- **Full with simultaneous push and pop.** FIFO full, `out_ready`=1, push 0x55 in the same cycle → level stays 4, no overrun, and 0x55 emerges last.
- **BREAK handling.** `rx_valid` with `rx_break`=1 and `rx_data`=0x00, BREAK_HOLD=8 → one `break_det` pulse at t+1; `rx_en` low for 8 cycles; FIFO unchanged; then RUN.
- **Idle and disable.** IDLE_CYCLES=100, no bytes → `idle`=1 at cycle 100 after entering RUN. An `rx_valid` clears it. `enable`=0 → `rx_en`=0 next cycle, and a later `rx_valid` is discarded without an overrun.
- **Reset mid-operation.** FIFO holds 3 bytes in RUN, assert `reset` for one cycle → all outputs at their reset values, `fifo_level`=0, state OFF.
